// File: rtl/uart_tx_queue.sv
// Byte FIFO feeding the UART transmitter.
// Issues one byte per ok/busy handshake cycle.
module uart_tx_queue #(
  parameter int DEPTH_LOG = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [7:0]           in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [DEPTH_LOG:0]   count,
  output logic                 empty,
  output logic                 overflow,
  output logic [7:0]           tx_data,
  output logic                 tx_ok,
  input  logic                 tx_busy
);

  localparam int DEPTH = 1 << DEPTH_LOG;
  localparam logic [DEPTH_LOG:0] FULL = (DEPTH_LOG + 1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_BUSY,
    WAIT_DONE
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [7:0]           r_mem [DEPTH];
  logic [DEPTH_LOG-1:0] r_head;
  logic [DEPTH_LOG-1:0] r_tail;
  logic [DEPTH_LOG:0]   r_count;
  logic                 r_overflow;
  logic [7:0]           r_tx_data;
  logic                 r_tx_ok;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_drop;

  // Readiness depends only on registered count, never on in_valid.
  assign in_ready = (r_count != FULL);
  assign empty    = (r_count == '0);
  assign count    = r_count;
  assign overflow = r_overflow;
  assign tx_data  = r_tx_data;
  assign tx_ok    = r_tx_ok;

  assign w_push = in_valid && in_ready;
  assign w_drop = in_valid && !in_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (!empty && !tx_busy) begin
          w_pop       = 1'b1;
          w_state_nxt = ISSUE;
        end
      end
      ISSUE: w_state_nxt = WAIT_BUSY;
      WAIT_BUSY: begin
        if (tx_busy) w_state_nxt = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (!tx_busy) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_tx_data  <= 8'h00;
      r_tx_ok    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_tx_ok <= w_pop;
      r_count <= r_count
               + (DEPTH_LOG + 1)'(w_push)
               - (DEPTH_LOG + 1)'(w_pop);
      if (w_push) r_tail <= r_tail + 1'b1;
      if (w_pop) begin
        r_head    <= r_head + 1'b1;
        r_tx_data <= r_mem[r_head];
      end
      if (w_drop) r_overflow <= 1'b1;
    end
  end

  // Storage needs no reset; pointers define what is valid.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_tail] <= in_data;
  end

endmodule

// File: tb/tb_uart_tx_queue.sv
// Self-checking bench for uart_tx_queue.
// Transmitter model plus scoreboard of issued bytes.
module tb_uart_tx_queue;

  localparam int BUSY_LEN = 3;

  logic       clk;
  logic       reset;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [4:0] count;
  logic       empty;
  logic       overflow;
  logic [7:0] tx_data;
  logic       tx_ok;
  logic       stall;
  logic       m_busy;
  int         m_cnt;
  int         checks;
  int         errors;
  int         n_strobe;
  logic [7:0] sb[$];

  typedef struct {
    logic       valid;
    logic [7:0] data;
    logic [4:0] exp_count;
    logic       exp_ready;
    logic       exp_ovf;
  } vec_t;

  vec_t vecs[17];

  uart_tx_queue #(.DEPTH_LOG(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .count    (count),
    .empty    (empty),
    .overflow (overflow),
    .tx_data  (tx_data),
    .tx_ok    (tx_ok),
    .tx_busy  (m_busy | stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Transmitter model and scoreboard consumer
  always @(negedge clk) begin
    if (tx_ok) begin
      n_strobe++;
      chk("strobe_while_busy", 32'(m_busy), 32'd0);
      if (sb.size() == 0) begin
        chk("unexpected_strobe", 32'(tx_data), 32'hFFFF);
      end else begin
        chk("tx_data_order", 32'(tx_data), 32'(sb.pop_front()));
      end
      m_busy = 1'b1;
      m_cnt  = BUSY_LEN;
    end else if (m_cnt > 0) begin
      m_cnt--;
      if (m_cnt == 0) m_busy = 1'b0;
    end
  end

  task automatic push(input logic [7:0] d, input bit track);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    if (track) sb.push_back(d);
  endtask

  task automatic idle_in();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && !m_busy && empty && !tx_ok) done = 1'b1;
    end
    chk("drain_timeout", 32'(done), 32'd1);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int s0;
    checks   = 0;
    errors   = 0;
    n_strobe = 0;
    m_busy   = 1'b0;
    m_cnt    = 0;
    stall    = 1'b0;
    reset    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;

    for (int i = 0; i < 17; i++) begin
      vecs[i].valid     = 1'b1;
      vecs[i].data      = 8'(i);
      vecs[i].exp_count = (i < 16) ? 5'(i + 1) : 5'd16;
      vecs[i].exp_ready = (i < 15);
      vecs[i].exp_ovf   = (i == 16);
    end

    repeat (2) @(negedge clk);
    chk("rst_tx_ok", 32'(tx_ok), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_overflow", 32'(overflow), 32'd0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Single byte
    push(8'h55, 1'b1);
    idle_in();
    chk("single_count1", 32'(count), 32'd1);
    chk("single_ok_early", 32'(tx_ok), 32'd0);
    @(negedge clk);
    chk("single_ok", 32'(tx_ok), 32'd1);
    chk("single_data", 32'(tx_data), 32'h55);
    chk("single_count0", 32'(count), 32'd0);
    @(negedge clk);
    chk("single_ok_pulse", 32'(tx_ok), 32'd0);
    drain();
    chk("single_strobes", 32'(n_strobe), 32'd1);

    // Burst ordering
    s0 = n_strobe;
    push(8'h01, 1'b1);
    push(8'h02, 1'b1);
    push(8'h03, 1'b1);
    idle_in();
    drain();
    chk("burst_strobes", 32'(n_strobe - s0), 32'd3);

    // Full / overflow, table driven
    stall = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 17; i++) begin
      push(vecs[i].data, vecs[i].exp_count != 5'(i) && i < 16);
      @(negedge clk);
      in_valid = 1'b0;
      chk($sformatf("full_count_%0d", i),
          32'(count), 32'(vecs[i].exp_count));
      chk($sformatf("full_ready_%0d", i),
          32'(in_ready), 32'(vecs[i].exp_ready));
      chk($sformatf("full_ovf_%0d", i),
          32'(overflow), 32'(vecs[i].exp_ovf));
      chk($sformatf("full_ok_%0d", i), 32'(tx_ok), 32'd0);
    end
    s0 = n_strobe;
    stall = 1'b0;
    drain();
    chk("full_strobes", 32'(n_strobe - s0), 32'd16);
    chk("ovf_sticky", 32'(overflow), 32'd1);

    // Simultaneous push and pop
    s0 = n_strobe;
    stall = 1'b1;
    push(8'hB1, 1'b1);
    push(8'hB2, 1'b1);
    push(8'hB3, 1'b1);
    idle_in();
    chk("sim_count3", 32'(count), 32'd3);
    push(8'hAA, 1'b1);
    stall = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    chk("sim_ok", 32'(tx_ok), 32'd1);
    chk("sim_count", 32'(count), 32'd3);
    drain();
    chk("sim_strobes", 32'(n_strobe - s0), 32'd4);

    // Reset mid-operation
    s0 = n_strobe;
    stall = 1'b1;
    for (int i = 0; i < 5; i++) push(8'hC0 + 8'(i), 1'b0);
    idle_in();
    chk("rm_count5", 32'(count), 32'd5);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    chk("rm_count", 32'(count), 32'd0);
    chk("rm_ok", 32'(tx_ok), 32'd0);
    chk("rm_ovf", 32'(overflow), 32'd0);
    chk("rm_empty", 32'(empty), 32'd1);
    repeat (3) @(negedge clk);
    stall = 1'b0;
    repeat (6) @(negedge clk);
    chk("rm_no_strobe", 32'(n_strobe - s0), 32'd0);

    // Busy at idle
    stall = 1'b1;
    push(8'h77, 1'b1);
    idle_in();
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("bi_hold_%0d", i), 32'(tx_ok), 32'd0);
      @(negedge clk);
    end
    stall = 1'b0;
    @(negedge clk);
    chk("bi_ok", 32'(tx_ok), 32'd1);
    chk("bi_data", 32'(tx_data), 32'h77);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
